bridge2xheep_obi_master: RTL and testbench
==========================================

# bridge2xheep_obi_master

Parametrised successor to the CW305-to-X-HEEP write-only bridge control. Takes command flags and operands from the CW305 host register file and runs complete OBI master transactions, writes and reads, on the X-HEEP bus. Adds an address register with configurable auto-increment stride, OBI response (`rvalid`) tracking, read-data capture, per-write byte enables and an optional transaction watchdog. Sits between the CW305 USB register file and an X-HEEP OBI slave port.

## Interface
- `ADDR_W`, default 32: OBI address width.
- `DATA_W`, default 32: OBI data width, multiple of 8; `BE_W = DATA_W/8`.
- `STRIDE`, default 4: byte increment applied to the address register after each completed access.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit, used only when the timeout macro is defined.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `addr_valid`  in  1  host level flag: new base address present.
- `wr_valid`  in  1  host level flag: write data present.
- `rd_valid`  in  1  host level flag: read command present.
- `addr_in`  in  ADDR_W  base address.
- `wdata_in`  in  DATA_W  write data.
- `be_in`  in  BE_W  write byte enables.
- `clr_addr_valid_n`, `clr_wr_valid_n`, `clr_rd_valid_n`  out  1 each  active-low one-cycle flag-clear pulses.
- `busy`  out  1  high while a command is being processed.
- `rdata_out`  out  DATA_W  last captured read data.
- `rdata_valid`  out  1  `rdata_out` holds data from the latest read.
- `timeout`  out  1  sticky watchdog flag.
- `cur_addr`  out  ADDR_W  address register value.
- `req`, `we`  out  1 each  OBI request and write enable.
- `be`  out  BE_W  OBI byte enables.
- `addr`  out  ADDR_W  OBI address, equal to `cur_addr`.
- `wdata`  out  DATA_W  OBI write data.
- `gnt`, `rvalid`  in  1 each  OBI grant and response valid.
- `rdata`  in  DATA_W  OBI read data.

## Operation
- States: RESET, IDLE, LD_ADDR, LD_CMD, REQ, WAIT_RSP, DONE, WAIT_CLR.
- RESET transitions to IDLE unconditionally.
- IDLE priority: `addr_valid` first, then `wr_valid`, then `rd_valid`. The winning command goes to LD_ADDR (address) or LD_CMD (write or read). With no flag set, remain in IDLE.
- LD_ADDR: load `cur_addr <= addr_in`, clear `timeout`, pulse `clr_addr_valid_n`, then go to WAIT_CLR.
- LD_CMD: latch `wdata_in` and `be_in`, or latch a read with `be` all ones. Latch the op type. A read clears `rdata_valid`. Then go to REQ.
- REQ: `req=1`. `we`, `be`, `addr` and `wdata` stay stable until `gnt`. On `gnt`, go to WAIT_RSP.
- WAIT_RSP: `req=0`. On `rvalid`, capture `rdata` if the op is a read and set `rdata_valid`. Then go to DONE.
- DONE: `cur_addr += STRIDE` modulo 2^ADDR_W (wraps silently). Pulse the clear for the serviced flag. Then go to WAIT_CLR.
- WAIT_CLR: stay until the serviced flag reads 0, then go to IDLE.
- `busy` is high in LD_ADDR, LD_CMD, REQ, WAIT_RSP and DONE.
- A flag that rises while another command is in progress waits in the host register and is serviced from IDLE.
- Reset asserted mid-transaction: `req` drops immediately and any outstanding OBI response is discarded.

## Timing
- Reset values:
  - `req`, `we`, `busy`, `rdata_valid`, `timeout`: 0.
  - `be`, `addr`, `wdata`, `rdata_out`, `cur_addr`: 0.
  - All `clr_*_n` outputs: 1.
- Commands are sampled in IDLE at edge N. LD_* runs in cycle N+1. `req` is first high in cycle N+2.
- With zero-wait `gnt` and `rvalid` one cycle after `gnt`:
  - DONE is in N+4.
  - The clear pulse is low for exactly that cycle.
  - `cur_addr` updates at the end of N+4.
- `rvalid` never arrives in the same cycle as `gnt` (OBI rule). `rvalid` during REQ is ignored.
- `rdata_out` updates on the edge after `rvalid` and holds until the next read's `rvalid`.

## Configuration
- `BRIDGE2XHEEP_TIMEOUT_EN` defined:
  - A counter runs while the FSM is in REQ or WAIT_RSP.
  - When it reaches `TIMEOUT_CYCLES`: deassert `req`, set `timeout`, leave `cur_addr` unchanged, and go to DONE to clear the flag.
  - Late `gnt` or `rvalid` is ignored.
- Undefined: no counter is built, `timeout` is tied to 0, and the block waits indefinitely.

## Structure
- `bridge2xheep_pkg`: state enum, op-type enum (`OP_WR`, `OP_RD`), default width and stride constants.
- One sub-module, `bridge2xheep_addr_cnt`: loadable address register with stride increment and wrap.

## Test plan
- Reset: pulse `rst_n` low mid-REQ. `req` drops asynchronously and every output takes its reset value.
- Address 0x0000_1000, then two writes (0xA5A5_0001 with be 0xF, 0x0000_00FF with be 0x1), `gnt` immediate, `rvalid` one cycle later. Expect OBI writes to 0x1000 and 0x1004 with matching data and be, and a final `cur_addr` of 0x1008.
- Read with `gnt` delayed 3 cycles and `rdata` 0xDEADBEEF. `req`, `addr` and `be` (0xF) stay stable for 4 cycles, then `rdata_out` = 0xDEADBEEF and `rdata_valid` = 1.
- `addr_valid` (0x2000) and `wr_valid` set in the same cycle. The address loads first, then the write goes to 0x2000.
- Address 0xFFFF_FFFC, one write. `cur_addr` wraps to 0x0000_0000.
- Macro defined, `TIMEOUT_CYCLES`=16, `gnt` never asserted. `req` drops after 16 cycles, `timeout` = 1, `clr_wr_valid_n` pulses once and `cur_addr` is unchanged. Macro undefined: `req` stays high.

Source files
------------

// File: rtl/bridge2xheep_pkg.sv
// Shared types and defaults for the CW305-to-X-HEEP OBI master bridge.
// The optional watchdog is enabled by defining BRIDGE2XHEEP_TIMEOUT_EN.
package bridge2xheep_pkg;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_STRIDE         = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_LD_ADDR,
    ST_LD_CMD,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE,
    ST_WAIT_CLR
  } state_e;

  typedef enum logic {
    OP_WR,
    OP_RD
  } op_e;

  // Which host flag the current command came from, so the right one is cleared.
  typedef enum logic [1:0] {
    FLG_ADDR,
    FLG_WR,
    FLG_RD
  } flag_e;

  function automatic logic state_busy(input state_e s);
    return (s == ST_LD_ADDR) || (s == ST_LD_CMD) || (s == ST_REQ) ||
           (s == ST_WAIT_RSP) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/bridge2xheep_addr_cnt.sv
// Loadable address register that advances by a fixed byte stride and wraps
// silently at 2^ADDR_W.
module bridge2xheep_addr_cnt
  import bridge2xheep_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned STRIDE = DEF_STRIDE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
    end else if (load) begin
      cur_addr <= load_val;
    end else if (inc) begin
      cur_addr <= cur_addr + STEP;
    end
  end

endmodule

// File: rtl/bridge2xheep_obi_master.sv
// Turns CW305 host command flags into complete OBI read/write transactions.
// Define BRIDGE2XHEEP_TIMEOUT_EN to build the transaction watchdog.
module bridge2xheep_obi_master
  import bridge2xheep_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned STRIDE         = DEF_STRIDE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  addr_valid,
  input  logic                  wr_valid,
  input  logic                  rd_valid,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [DATA_W-1:0]     wdata_in,
  input  logic [DATA_W/8-1:0]   be_in,
  output logic                  clr_addr_valid_n,
  output logic                  clr_wr_valid_n,
  output logic                  clr_rd_valid_n,
  output logic                  busy,
  output logic [DATA_W-1:0]     rdata_out,
  output logic                  rdata_valid,
  output logic                  timeout,
  output logic [ADDR_W-1:0]     cur_addr,
  output logic                  req,
  output logic                  we,
  output logic [DATA_W/8-1:0]   be,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  input  logic                  gnt,
  input  logic                  rvalid,
  input  logic [DATA_W-1:0]     rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  flag_e             svc_q;
  op_e               op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q;
  logic              svc_flag;
  logic              tmo_hit;
  logic              aborted;

  // State register: async reset lands in RESET, which drops req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    svc_flag = 1'b0;
    unique case (svc_q)
      FLG_ADDR: svc_flag = addr_valid;
      FLG_WR:   svc_flag = wr_valid;
      FLG_RD:   svc_flag = rd_valid;
      default:  svc_flag = 1'b0;
    endcase
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:    state_d = ST_IDLE;
      ST_IDLE: begin
        if (addr_valid) begin
          state_d = ST_LD_ADDR;
        end else if (wr_valid || rd_valid) begin
          state_d = ST_LD_CMD;
        end
      end
      ST_LD_ADDR:  state_d = ST_WAIT_CLR;
      ST_LD_CMD:   state_d = ST_REQ;
      ST_REQ: begin
        if (gnt) begin
          state_d = ST_WAIT_RSP;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT_RSP: begin
        if (rvalid || tmo_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:     state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        if (!svc_flag) begin
          state_d = ST_IDLE;
        end
      end
      default:     state_d = ST_RESET;
    endcase
  end

  always_comb begin
    req              = (state_q == ST_REQ);
    busy             = state_busy(state_q);
    clr_addr_valid_n = 1'b1;
    clr_wr_valid_n   = 1'b1;
    clr_rd_valid_n   = 1'b1;
    if (state_q == ST_LD_ADDR) begin
      clr_addr_valid_n = 1'b0;
    end else if (state_q == ST_DONE) begin
      clr_wr_valid_n = (svc_q != FLG_WR);
      clr_rd_valid_n = (svc_q != FLG_RD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      svc_q         <= FLG_ADDR;
      op_q          <= OP_RD;
      wdata_q       <= '0;
      be_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (addr_valid) begin
          svc_q <= FLG_ADDR;
        end else if (wr_valid) begin
          svc_q <= FLG_WR;
        end else if (rd_valid) begin
          svc_q <= FLG_RD;
        end
      end
      if (state_q == ST_LD_CMD) begin
        if (svc_q == FLG_WR) begin
          op_q    <= OP_WR;
          wdata_q <= wdata_in;
          be_q    <= be_in;
        end else begin
          op_q          <= OP_RD;
          be_q          <= '1;
          rdata_valid_q <= 1'b0;
        end
      end
      // Responses outside WAIT_RSP (stale after reset or a timeout) are ignored.
      if (state_q == ST_WAIT_RSP && rvalid && op_q == OP_RD) begin
        rdata_q       <= rdata;
        rdata_valid_q <= 1'b1;
      end
    end
  end

`ifdef BRIDGE2XHEEP_TIMEOUT_EN
  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;
  logic             abort_q;
  logic             bus_phase;
  logic             tmo_fire;

  assign bus_phase = (state_q == ST_REQ) || (state_q == ST_WAIT_RSP);
  assign tmo_hit   = bus_phase && (tmo_cnt_q >= TMO_LAST);
  assign tmo_fire  = tmo_hit && (((state_q == ST_REQ) && !gnt) ||
                                 ((state_q == ST_WAIT_RSP) && !rvalid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (bus_phase) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  // abort_q is per transaction and suppresses the address step; timeout_q is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      if (state_q == ST_LD_ADDR) begin
        timeout_q <= 1'b0;
      end
      if (state_q == ST_LD_CMD) begin
        abort_q <= 1'b0;
      end
      if (tmo_fire) begin
        timeout_q <= 1'b1;
        abort_q   <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
  assign aborted = abort_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
  assign aborted = 1'b0;
`endif

  bridge2xheep_addr_cnt #(
    .ADDR_W (ADDR_W),
    .STRIDE (STRIDE)
  ) u_addr_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == ST_LD_ADDR),
    .load_val (addr_in),
    .inc      ((state_q == ST_DONE) && !aborted),
    .cur_addr (cur_addr)
  );

  assign we          = (op_q == OP_WR);
  assign be          = be_q;
  assign addr        = cur_addr;
  assign wdata       = wdata_q;
  assign rdata_out   = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_bridge2xheep_obi_master.sv
// Scoreboard bench for bridge2xheep_obi_master: expected OBI transactions and
// read data are queued by the stimulus and checked by an independent monitor.
module tb_bridge2xheep_obi_master;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_valid, wr_valid, rd_valid;
  logic [31:0] addr_in, wdata_in;
  logic [3:0]  be_in;
  logic        clr_addr_valid_n, clr_wr_valid_n, clr_rd_valid_n;
  logic        busy, rdata_valid, timeout;
  logic [31:0] rdata_out, cur_addr;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad = 0;
  int          n_clr_addr = 0, n_clr_wr = 0, n_clr_rd = 0;
  int          last_req_len = 0;

  logic        no_gnt = 1'b0;
  int          gnt_delay = 0;
  logic [31:0] slv_rdata = '0;

  always #5 clk = ~clk;

  bridge2xheep_obi_master #(
    .ADDR_W(32), .DATA_W(32), .STRIDE(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_valid(addr_valid), .wr_valid(wr_valid), .rd_valid(rd_valid),
    .addr_in(addr_in), .wdata_in(wdata_in), .be_in(be_in),
    .clr_addr_valid_n(clr_addr_valid_n), .clr_wr_valid_n(clr_wr_valid_n),
    .clr_rd_valid_n(clr_rd_valid_n),
    .busy(busy), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .timeout(timeout), .cur_addr(cur_addr),
    .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, req, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdata_valid"}, rdata_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_be"}, be, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_rdata_out"}, rdata_out, 0);
    check({tag, "_cur_addr"}, cur_addr, 0);
    check({tag, "_clr_n"}, {clr_addr_valid_n, clr_wr_valid_n, clr_rd_valid_n}, 3'b111);
  endtask

  // Host register model: raise the requested flags, drop each one when its
  // clear pulse is seen, then let the bridge settle back to IDLE.
  task automatic run_cmd(input logic a, input logic w, input logic r);
    int guard = 0;
    @(negedge clk);
    if (a) addr_valid = 1'b1;
    if (w) wr_valid = 1'b1;
    if (r) rd_valid = 1'b1;
    while ((addr_valid || wr_valid || rd_valid) && guard < 400) begin
      @(negedge clk);
      guard++;
      if (!clr_addr_valid_n) begin addr_valid = 1'b0; n_clr_addr++; end
      if (!clr_wr_valid_n) begin wr_valid = 1'b0; n_clr_wr++; end
      if (!clr_rd_valid_n) begin rd_valid = 1'b0; n_clr_rd++; end
    end
    if (guard >= 400) begin
      fail_now("cmd_flag_clear");
      addr_valid = 1'b0;
      wr_valid   = 1'b0;
      rd_valid   = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  // OBI slave: grant after gnt_delay request cycles, respond one cycle after grant.
  initial begin
    int wcnt = 0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gnt    = 1'b0;
        rvalid = 1'b0;
        wcnt   = 0;
      end else begin
        rvalid = gnt;
        rdata  = gnt ? slv_rdata : 32'h0;
        if (req && !gnt && !no_gnt) begin
          if (wcnt >= gnt_delay) begin
            gnt  = 1'b1;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          gnt  = 1'b0;
          wcnt = 0;
        end
      end
    end
  end

  // Monitor: request stability, handshake contents and read-data capture.
  initial begin
    int          req_len = 0;
    logic        rv_prev = 1'b0;
    logic [68:0] first = '0;
    txn_t        t;
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_len = 0;
        rv_prev = 1'b0;
      end else begin
        if (req) begin
          if (req_len == 0) first = {we, addr, wdata, be};
          else check("req_stable", {we, addr, wdata, be}, first);
          req_len++;
          if (gnt) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_obi_txn");
            end else begin
              t = exp_q.pop_front();
              check("obi_we", we, t.we);
              check("obi_addr", addr, t.addr);
              check("obi_be", be, t.be);
              if (t.we) check("obi_wdata", wdata, t.wdata);
            end
          end
        end else begin
          if (req_len > 0) last_req_len = req_len;
          req_len = 0;
        end
        if (rdata_valid && !rv_prev) begin
          if (rd_q.size() == 0) begin
            fail_now("unexpected_rdata_valid");
          end else begin
            exp_rd = rd_q.pop_front();
            check("rdata_out", rdata_out, exp_rd);
          end
        end
        rv_prev = rdata_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n      = 1'b0;
    addr_valid = 1'b0;
    wr_valid   = 1'b0;
    rd_valid   = 1'b0;
    addr_in    = '0;
    wdata_in   = '0;
    be_in      = '0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Reset asserted while a write is stuck in REQ.
    no_gnt   = 1'b1;
    wdata_in = 32'h1111_2222;
    be_in    = 4'hF;
    wr_valid = 1'b1;
    guard = 0;
    while (!req && guard < 20) begin @(negedge clk); guard++; end
    if (!req) fail_now("mid_req_no_req");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_req");
    wr_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    no_gnt = 1'b0;
    repeat (2) @(negedge clk);

    // Base address, then two zero-wait writes.
    addr_in = 32'h0000_1000;
    run_cmd(1, 0, 0);
    check("ld_addr_1000", cur_addr, 32'h0000_1000);
    wdata_in = 32'hA5A5_0001;
    be_in    = 4'hF;
    exp_q.push_back('{1'b1, 32'h0000_1000, 32'hA5A5_0001, 4'hF});
    run_cmd(0, 1, 0);
    check("cur_addr_after_wr1", cur_addr, 32'h0000_1004);
    wdata_in = 32'h0000_00FF;
    be_in    = 4'h1;
    exp_q.push_back('{1'b1, 32'h0000_1004, 32'h0000_00FF, 4'h1});
    run_cmd(0, 1, 0);
    check("cur_addr_after_wr2", cur_addr, 32'h0000_1008);

    // Read with grant delayed three cycles.
    gnt_delay = 3;
    slv_rdata = 32'hDEAD_BEEF;
    exp_q.push_back('{1'b0, 32'h0000_1008, 32'h0, 4'hF});
    rd_q.push_back(32'hDEAD_BEEF);
    run_cmd(0, 0, 1);
    gnt_delay = 0;
    check("rd_req_len", last_req_len, 4);
    check("rd_rdata_valid", rdata_valid, 1);
    check("rd_rdata_hold", rdata_out, 32'hDEAD_BEEF);
    check("cur_addr_after_rd", cur_addr, 32'h0000_100C);

    // Address and write raised together: address must load first.
    addr_in  = 32'h0000_2000;
    wdata_in = 32'h1234_5678;
    be_in    = 4'hC;
    exp_q.push_back('{1'b1, 32'h0000_2000, 32'h1234_5678, 4'hC});
    run_cmd(1, 1, 0);
    check("cur_addr_after_both", cur_addr, 32'h0000_2004);
    check("rdata_held_after_wr", rdata_out, 32'hDEAD_BEEF);

    // Address wrap at the top of the space.
    addr_in = 32'hFFFF_FFFC;
    run_cmd(1, 0, 0);
    wdata_in = 32'hCAFE_0000;
    be_in    = 4'h3;
    exp_q.push_back('{1'b1, 32'hFFFF_FFFC, 32'hCAFE_0000, 4'h3});
    run_cmd(0, 1, 0);
    check("cur_addr_wrap", cur_addr, 32'h0000_0000);

    // Slave never grants.
    wdata_in = 32'h0000_0005;
    be_in    = 4'hF;
`ifdef BRIDGE2XHEEP_TIMEOUT_EN
    begin
      int n0;
      n0     = n_clr_wr;
      no_gnt = 1'b1;
      run_cmd(0, 1, 0);
      no_gnt = 1'b0;
      check("tmo_req_len", last_req_len, 16);
      check("tmo_flag", timeout, 1);
      check("tmo_clr_pulses", n_clr_wr - n0, 1);
      check("tmo_cur_addr", cur_addr, 32'h0000_0000);
      check("tmo_busy", busy, 0);
    end
`else
    exp_q.push_back('{1'b1, 32'h0000_0000, 32'h0000_0005, 4'hF});
    no_gnt = 1'b1;
    fork
      run_cmd(0, 1, 0);
      begin
        repeat (40) @(negedge clk);
        check("nogrant_req_held", req, 1);
        check("nogrant_timeout", timeout, 0);
        no_gnt = 1'b0;
      end
    join
    check("nogrant_cur_addr", cur_addr, 32'h0000_0004);
`endif

    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
